dma_reg_arbiter: RTL and testbench
==================================

DMA_REG_ARBITER -- requirements
Module: dma_reg_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, fixed number of requesters; only 4 is supported.
REQ-002 SHALL have port i_clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_pnreset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_req  input  4  per-requester access request; held high until o_ack.
REQ-005 SHALL have port i_we  input  4  per-requester direction: 1 write, 0 read.
REQ-006 SHALL have port i_addr  input  32  four 8-bit register offsets; requester k uses bits [8k+7:8k].
REQ-007 SHALL have port i_wdata  input  128  four 32-bit write words; requester k uses bits [32k+31:32k].
REQ-008 SHALL have port o_ack  output  4  one-hot, one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port o_rdata  output  32  read data, valid in the o_ack cycle and held until the next completion.
REQ-010 SHALL have port o_gnt  output  4  one-hot current owner; zero when idle.
REQ-011 SHALL have port o_addr  output  32  register address {24'd0, latched offset}.
REQ-012 SHALL have port o_read_en  output  1  one-cycle register read strobe.
REQ-013 SHALL have port o_write_en  output  1  one-cycle register write strobe.
REQ-014 SHALL have port o_byte_strobe  output  4  constant 4'b1111.
REQ-015 SHALL have port o_wdata  output  32  latched write word.
REQ-016 SHALL have port i_rdata  input  32  register read data, valid in the cycle o_read_en is high.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 IDLE with i_req!=0 SHALL select one requester per REQ-024, latch its i_we, offset and write word, set o_gnt, and go to ACCESS; with i_req==0 it SHALL stay in IDLE.
REQ-019 ACCESS SHALL drive o_read_en (latched we=0) or o_write_en (latched we=1) high for exactly one cycle, then go to RESP.
REQ-020 In ACCESS with a read, i_rdata SHALL be registered into o_rdata at the end of the cycle.
REQ-021 RESP SHALL pulse o_ack for the owner, clear o_gnt, advance the round-robin pointer to owner+1 mod 4, and go to IDLE.
REQ-022 Latency SHALL be: request sampled in IDLE cycle T, strobe in T+1, o_ack in T+2; the next grant is no earlier than T+3.
REQ-023 o_addr and o_wdata SHALL change only at grant; later changes on i_addr/i_wdata/i_we SHALL be ignored.
REQ-024 Selection SHALL be round-robin: the first requesting index searching upward from the pointer, wrapping 3->0.
REQ-025 If the owner drops i_req after grant, the transaction SHALL still complete and o_ack SHALL still pulse.
REQ-026 If i_req is still high in the IDLE cycle after o_ack, it SHALL be a new request.
REQ-027 Simultaneous requests SHALL be served one per transaction in pointer order, and no requester SHALL wait more than 3 transactions.
REQ-028 At most one of o_read_en/o_write_en SHALL be high in any cycle, and never outside ACCESS.

Reset
REQ-029 Assertion of i_pnreset SHALL immediately force: state IDLE, pointer 0, o_gnt 0, o_ack 0, o_read_en 0, o_write_en 0, o_rdata 0, o_addr 0, o_wdata 0.
REQ-030 Reset mid-transaction SHALL abort it with no o_ack, and SHALL NOT issue any strobe on release.

Configuration
REQ-031 With macro DMA_REG_ARB_FIXED_PRIO_EN defined, requester 0 SHALL win whenever i_req[0] is high in IDLE, and requesters 1-3 SHALL round-robin among themselves; grants to 0 SHALL NOT move their pointer.
REQ-032 Without DMA_REG_ARB_FIXED_PRIO_EN, all four requesters SHALL be pure round-robin per REQ-024.

Verification
REQ-033 After reset, single read: i_req=4'b0010, i_we=0, offset 8'h14, i_rdata=32'hDEADBEEF -> o_read_en in T+1 with o_addr=32'h14; o_ack=4'b0010 and o_rdata=32'hDEADBEEF in T+2.
REQ-034 Single write: requester 2, offset 8'h08, word 32'h12345678 -> o_write_en one cycle with o_wdata=32'h12345678, o_addr=32'h08; o_ack=4'b0100.
REQ-035 All four requesting continuously from reset -> grant order 0,1,2,3,0 with one grant every 3 cycles (round-robin build); with the macro defined -> 0,0,0,... while i_req[0] is held.
REQ-036 Requester 3 drops i_req in ACCESS -> the strobe still occurs and o_ack=4'b1000 in the next cycle.
REQ-037 i_pnreset asserted during ACCESS -> all outputs 0 immediately; no o_ack and no strobe after release until a new request.
REQ-038 i_addr changed from 8'h04 to 8'h0C one cycle after grant -> o_addr stays 32'h04 through the strobe.

Source files
------------

// File: rtl/dma_reg_arbiter_if.sv
// rtl/dma_reg_arbiter_if.sv - requester and register-bus signals of the DMA register arbiter
interface dma_reg_arbiter_if;
    logic [3:0]   i_req;
    logic [3:0]   i_we;
    logic [31:0]  i_addr;
    logic [127:0] i_wdata;
    logic [3:0]   o_ack;
    logic [31:0]  o_rdata;
    logic [3:0]   o_gnt;
    logic [31:0]  o_addr;
    logic         o_read_en;
    logic         o_write_en;
    logic [3:0]   o_byte_strobe;
    logic [31:0]  o_wdata;
    logic [31:0]  i_rdata;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_rdata,
        output o_ack, o_rdata, o_gnt, o_addr, o_read_en, o_write_en, o_byte_strobe, o_wdata
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_rdata,
        input  o_ack, o_rdata, o_gnt, o_addr, o_read_en, o_write_en, o_byte_strobe, o_wdata
    );
endinterface

// File: rtl/dma_reg_arbiter.sv
// rtl/dma_reg_arbiter.sv - round-robin arbiter of four requesters onto one register port
// Optional DMA_REG_ARB_FIXED_PRIO_EN: requester 0 has absolute priority, 1-3 round-robin.
module dma_reg_arbiter #(
    parameter int NREQ = 4
) (
    input  logic             i_clk,
    input  logic             i_pnreset,
    dma_reg_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_idx;
    logic          r_we;
    logic [7:0]    r_off;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [2:0]    w_pick;
    logic          w_sel_vld;
    logic [1:0]    w_sel;
    logic [3:0]    w_owner_oh;

`ifdef DMA_REG_ARB_FIXED_PRIO_EN
    // Round-robin over requesters 1..3 only; base is always in 1..3.
    function automatic logic [2:0] pick_hi(input logic [3:0] req, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] k;
        res = '0;
        for (int i = 2; i >= 0; i--) begin
            k = (int'(base) + i > 3) ? 2'(int'(base) + i - 3) : 2'(int'(base) + i);
            if (req[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    always_comb begin
        w_pick = '0;
        if (bus.i_req[0]) w_pick = 3'b100;
        else              w_pick = pick_hi(bus.i_req, (r_ptr == 2'd0) ? 2'd1 : r_ptr);
    end
`else
    // Downward scan so the smallest distance from the pointer is written last and wins.
    function automatic logic [2:0] pick_rr(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] k;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            k = start + 2'(i);
            if (req[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    always_comb begin
        w_pick = '0;
        w_pick = pick_rr(bus.i_req, r_ptr);
    end
`endif

    assign w_sel_vld  = w_pick[2];
    assign w_sel      = w_pick[1:0];
    assign w_owner_oh = 4'b0001 << r_idx;

    always_ff @(posedge i_clk or negedge i_pnreset) begin
        if (!i_pnreset) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_sel_vld) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_pnreset) begin
        if (!i_pnreset) begin
            r_ptr   <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_off   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_sel_vld) begin
                r_idx   <= w_sel;
                r_we    <= bus.i_we[w_sel];
                r_off   <= bus.i_addr[{w_sel, 3'b000} +: 8];
                r_wdata <= bus.i_wdata[{w_sel, 5'b00000} +: 32];
            end
            if (r_state == ACCESS && !r_we) r_rdata <= bus.i_rdata;
            if (r_state == RESP) begin
`ifdef DMA_REG_ARB_FIXED_PRIO_EN
                if (r_idx != 2'd0) r_ptr <= (r_idx == 2'd3) ? 2'd1 : r_idx + 2'd1;
`else
                r_ptr <= r_idx + 2'd1;
`endif
            end
        end
    end

    assign bus.o_gnt         = (r_state != IDLE) ? w_owner_oh : 4'b0000;
    assign bus.o_ack         = (r_state == RESP) ? w_owner_oh : 4'b0000;
    assign bus.o_read_en     = (r_state == ACCESS) && !r_we;
    assign bus.o_write_en    = (r_state == ACCESS) && r_we;
    assign bus.o_addr        = {24'd0, r_off};
    assign bus.o_wdata       = r_wdata;
    assign bus.o_rdata       = r_rdata;
    assign bus.o_byte_strobe = 4'b1111;
endmodule

// File: tb/tb_dma_reg_arbiter.sv
// tb/tb_dma_reg_arbiter.sv - self-checking bench for dma_reg_arbiter
module tb_dma_reg_arbiter;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dma_reg_arbiter_if bus();

    dma_reg_arbiter #(.NREQ(4)) dut (
        .i_clk     (clk),
        .i_pnreset (rstn),
        .bus       (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: a grant at edge number m_start owns the bus for
    // the next two cycles (strobe, then ack); the next grant is three edges later.
    int          cyc;
    int          m_start;
    int          m_owner;
    logic        m_we;
    logic [7:0]  m_off;
    logic [31:0] m_wd;
    logic [31:0] m_rd;
    int          m_ptr;

    function automatic int model_pick(input logic [3:0] req, input int ptr);
        int s;
        int k;
`ifdef DMA_REG_ARB_FIXED_PRIO_EN
        if (req[0]) return 0;
        s = (ptr == 0) ? 1 : ptr;
        for (int i = 0; i < 3; i++) begin
            k = 1 + ((s - 1 + i) % 3);
            if (req[k]) return k;
        end
`else
        s = ptr;
        for (int i = 0; i < 4; i++) begin
            k = (s + i) % 4;
            if (req[k]) return k;
        end
`endif
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        int k;
        if (!rstn) begin
            cyc = 0; m_start = -1; m_owner = 0; m_we = 1'b0;
            m_off = '0; m_wd = '0; m_rd = '0; m_ptr = 0;
        end else begin
            cyc++;
            if (m_start < 0) begin
                k = model_pick(bus.i_req, m_ptr);
                if (k >= 0) begin
                    m_start = cyc; m_owner = k; m_we = bus.i_we[k];
                    m_off = bus.i_addr[8*k +: 8]; m_wd = bus.i_wdata[32*k +: 32];
                end
            end else if (cyc - m_start == 1) begin
                if (!m_we) m_rd = bus.i_rdata;
            end else if (cyc - m_start == 2) begin
`ifdef DMA_REG_ARB_FIXED_PRIO_EN
                if (m_owner != 0) m_ptr = (m_owner % 3) + 1;
`else
                m_ptr = (m_owner + 1) % 4;
`endif
                m_start = -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg, ea;
        logic       er, ew;
        eg = '0; ea = '0; er = 1'b0; ew = 1'b0;
        if (m_start >= 0) begin
            eg = 4'b0001 << m_owner;
            if (cyc == m_start) begin er = !m_we; ew = m_we; end
            else ea = eg;
        end
        chk("m_gnt",   128'(bus.o_gnt),         128'(eg));
        chk("m_ack",   128'(bus.o_ack),         128'(ea));
        chk("m_rd_en", 128'(bus.o_read_en),     128'(er));
        chk("m_wr_en", 128'(bus.o_write_en),    128'(ew));
        chk("m_addr",  128'(bus.o_addr),        128'({24'd0, m_off}));
        chk("m_wdata", 128'(bus.o_wdata),       128'(m_wd));
        chk("m_rdata", 128'(bus.o_rdata),       128'(m_rd));
        chk("m_bstrb", 128'(bus.o_byte_strobe), 128'(4'b1111));
    end

    task automatic set_req(input int k, input logic we, input logic [7:0] off, input logic [31:0] wd);
        bus.i_req[k]           = 1'b1;
        bus.i_we[k]            = we;
        bus.i_addr[8*k +: 8]   = off;
        bus.i_wdata[32*k +: 32] = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          acks_idx [5];
    int          acks_cyc [5];
    int          n_ack;
    int          tcyc;
    int          exp_order [5];
    logic [3:0]  first_g, second_g;

    initial begin
        bus.i_req = '0; bus.i_we = '0; bus.i_addr = '0; bus.i_wdata = '0;
        bus.i_rdata = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   128'(bus.o_gnt),      128'(4'b0000));
        chk("rst_ack",   128'(bus.o_ack),      128'(4'b0000));
        chk("rst_rden",  128'(bus.o_read_en),  128'(1'b0));
        chk("rst_wren",  128'(bus.o_write_en), 128'(1'b0));
        chk("rst_addr",  128'(bus.o_addr),     128'(32'h0));
        chk("rst_rdata", 128'(bus.o_rdata),    128'(32'h0));
        rstn = 1'b1;
        tick();

        // single read by requester 1
        set_req(1, 1'b0, 8'h14, 32'h0);
        tick();
        @(negedge clk);
        chk("rd_strobe", 128'(bus.o_read_en),  128'(1'b1));
        chk("rd_addr",   128'(bus.o_addr),     128'(32'h14));
        chk("rd_gnt",    128'(bus.o_gnt),      128'(4'b0010));
        tick();
        bus.i_req = '0;
        @(negedge clk);
        chk("rd_ack",    128'(bus.o_ack),      128'(4'b0010));
        chk("rd_data",   128'(bus.o_rdata),    128'(32'hDEADBEEF));
        tick();
        bus.i_rdata = 32'h0BADF00D;
        @(negedge clk);
        chk("rd_hold",   128'(bus.o_rdata),    128'(32'hDEADBEEF));
        tick();

        // single write by requester 2
        set_req(2, 1'b1, 8'h08, 32'h12345678);
        tick();
        @(negedge clk);
        chk("wr_strobe", 128'(bus.o_write_en), 128'(1'b1));
        chk("wr_nord",   128'(bus.o_read_en),  128'(1'b0));
        chk("wr_wdata",  128'(bus.o_wdata),    128'(32'h12345678));
        chk("wr_addr",   128'(bus.o_addr),     128'(32'h08));
        tick();
        bus.i_req = '0;
        @(negedge clk);
        chk("wr_ack",    128'(bus.o_ack),      128'(4'b0100));
        chk("wr_rdata",  128'(bus.o_rdata),    128'(32'hDEADBEEF));
        tick();

        // address change after grant is ignored
        set_req(0, 1'b0, 8'h04, 32'h0);
        tick();
        bus.i_addr[7:0] = 8'h0C;
        @(negedge clk);
        chk("lat_addr",  128'(bus.o_addr),     128'(32'h04));
        chk("lat_rden",  128'(bus.o_read_en),  128'(1'b1));
        tick();
        bus.i_req = '0;
        @(negedge clk);
        chk("lat_ack",   128'(bus.o_ack),      128'(4'b0001));
        chk("lat_rdata", 128'(bus.o_rdata),    128'(32'h0BADF00D));
        tick();

        // owner drops request during ACCESS
        set_req(3, 1'b1, 8'h20, 32'hA5A5A5A5);
        tick();
        bus.i_req = '0;
        @(negedge clk);
        chk("drop_wren", 128'(bus.o_write_en), 128'(1'b1));
        chk("drop_gnt",  128'(bus.o_gnt),      128'(4'b1000));
        tick();
        @(negedge clk);
        chk("drop_ack",  128'(bus.o_ack),      128'(4'b1000));
        tick();

        // move pointer to 2, then contend 0 against 3
        set_req(1, 1'b0, 8'h30, 32'h0);
        tick(); tick();
        bus.i_req = '0;
        tick();
        set_req(0, 1'b0, 8'h40, 32'h0);
        set_req(3, 1'b1, 8'h44, 32'h77778888);
`ifdef DMA_REG_ARB_FIXED_PRIO_EN
        first_g = 4'b0001; second_g = 4'b1000;
`else
        first_g = 4'b1000; second_g = 4'b0001;
`endif
        tick();
        @(negedge clk);
        chk("ptr_first", 128'(bus.o_gnt), 128'(first_g));
        tick();
        bus.i_req = bus.i_req & ~first_g;
        tick(); tick();
        @(negedge clk);
        chk("ptr_second", 128'(bus.o_gnt), 128'(second_g));
        tick();
        bus.i_req = '0;
        tick(); tick();

        // reset during ACCESS
        set_req(0, 1'b0, 8'h50, 32'h0);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_gnt",   128'(bus.o_gnt),      128'(4'b0000));
        chk("ar_ack",   128'(bus.o_ack),      128'(4'b0000));
        chk("ar_rden",  128'(bus.o_read_en),  128'(1'b0));
        chk("ar_wren",  128'(bus.o_write_en), 128'(1'b0));
        chk("ar_addr",  128'(bus.o_addr),     128'(32'h0));
        chk("ar_wdata", 128'(bus.o_wdata),    128'(32'h0));
        chk("ar_rdata", 128'(bus.o_rdata),    128'(32'h0));
        bus.i_req = '0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ar_quiet", 128'({bus.o_read_en, bus.o_write_en, bus.o_ack}), 128'(6'b0));
        end
        tick();

        // all four requesting from reset
        rstn = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, 8'(8'h60 + k), 32'h0);
        tick();
        rstn = 1'b1;
        n_ack = 0; tcyc = 0;
        for (int i = 0; i < 5; i++) begin acks_idx[i] = -1; acks_cyc[i] = -100; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tcyc++;
            if (bus.o_ack != 4'b0000 && n_ack < 5) begin
                acks_idx[n_ack] = $clog2(bus.o_ack);
                acks_cyc[n_ack] = tcyc;
                n_ack++;
            end
        end
`ifdef DMA_REG_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 128'(acks_idx[i]), 128'(exp_order[i]));
            if (i > 0) chk("rr_spacing", 128'(acks_cyc[i] - acks_cyc[i-1]), 128'(3));
        end
        bus.i_req = '0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
